// File: rtl/nqueens_pkg.sv
// Shared types and constants for the N-Queens controller and its datapath.
package nqueens_pkg;

  localparam int DW    = 3;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    BACKTRACK,
    RESTORE
  } state_t;

  typedef logic [DW-1:0]    idx_t;
  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/nqueens_controller.sv
// Iterative backtracking search over an N x N board, driving the queen-position
// register file and IsSafe checker and counting every complete placement.
module nqueens_controller
  import nqueens_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DW-1:0]    n,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] solutions,
  output logic [DW-1:0]    row,
  output logic [DW-1:0]    col,
  input  logic             safe,
  output logic [DW-1:0]    address_3,
  output logic [DW-1:0]    data_in_3,
  output logic             load_3,
  output logic             read_3,
  input  logic [DW-1:0]    data_out_3
);

  state_t state, state_d;
  idx_t   n_q, n_d;
  idx_t   row_d, col_d;
  cnt_t   sol_d;
  logic   busy_d, done_d;

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state;
    n_d       = n_q;
    row_d     = row;
    col_d     = col;
    sol_d     = solutions;
    busy_d    = busy;
    done_d    = done;
    load_3    = 1'b0;
    read_3    = 1'b0;
    address_3 = '0;
    data_in_3 = '0;

    unique case (state)
      IDLE: begin
        if (start) begin
          n_d     = n;
          row_d   = '0;
          col_d   = '0;
          sol_d   = '0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = CHECK;
        end
      end

      CHECK: begin
        address_3 = row;
        data_in_3 = col;
        if (col == n_q) begin
          state_d = BACKTRACK;
        end else if (safe) begin
          // The write must land on the same edge that advances row, so the
          // next IsSafe evaluation already sees this queen.
          load_3 = 1'b1;
          if (row == n_q - idx_t'(1)) begin
            sol_d = solutions + cnt_t'(1);
            col_d = col + idx_t'(1);
          end else begin
            row_d = row + idx_t'(1);
            col_d = '0;
          end
        end else begin
          col_d = col + idx_t'(1);
        end
      end

      BACKTRACK: begin
        if (row == '0) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          read_3    = 1'b1;
          address_3 = row - idx_t'(1);
          row_d     = row - idx_t'(1);
          state_d   = RESTORE;
        end
      end

      RESTORE: begin
        // Resume the previous row one column past its last placed queen.
        col_d   = data_out_3 + idx_t'(1);
        state_d = CHECK;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      n_q       <= '0;
      row       <= '0;
      col       <= '0;
      solutions <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      n_q       <= n_d;
      row       <= row_d;
      col       <= col_d;
      solutions <= sol_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_nqueens_controller.sv
// Directed bench: drives the controller against a behavioural register file
// and IsSafe checker, comparing solution counts and handshake timing.
module tb_nqueens_controller;
  import nqueens_pkg::*;

  logic             clk;
  logic             reset;
  logic             start;
  logic [DW-1:0]    n;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] solutions;
  logic [DW-1:0]    row;
  logic [DW-1:0]    col;
  logic             safe;
  logic [DW-1:0]    address_3;
  logic [DW-1:0]    data_in_3;
  logic             load_3;
  logic             read_3;
  logic [DW-1:0]    data_out_3;

  int asserts  = 0;
  int failures = 0;

  nqueens_controller dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .n          (n),
    .busy       (busy),
    .done       (done),
    .solutions  (solutions),
    .row        (row),
    .col        (col),
    .safe       (safe),
    .address_3  (address_3),
    .data_in_3  (data_in_3),
    .load_3     (load_3),
    .read_3     (read_3),
    .data_out_3 (data_out_3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural datapath: 8x3 register file with registered read, plus IsSafe.
  logic [DW-1:0] rf [8];
  logic [DW-1:0] rd_q;

  always @(posedge clk) begin
    if (load_3) rf[address_3] <= data_in_3;
    if (read_3) rd_q <= rf[address_3];
  end
  assign data_out_3 = rd_q;

  always_comb begin
    safe = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(row)) begin
        int dc;
        dc = int'(rf[i]) - int'(col);
        if (dc < 0) dc = -dc;
        if (dc == 0 || dc == int'(row) - i) safe = 1'b0;
      end
    end
  end

  // Protocol monitors sampled on the falling edge.
  int       overlap_cnt = 0;
  bit       cap_en   = 1'b0;
  bit       cap_done = 1'b0;
  logic [DW-1:0] cap_addr, cap_data, cap_r0, cap_r1, cap_r2;

  always @(negedge clk) begin
    if (load_3 && read_3) overlap_cnt++;
    if (cap_en && !cap_done && load_3 && row == 3'd3) begin
      cap_done = 1'b1;
      cap_addr = address_3;
      cap_data = data_in_3;
      cap_r0   = rf[0];
      cap_r1   = rf[1];
      cap_r2   = rf[2];
    end
  end

  task automatic start_search(input logic [DW-1:0] nv);
    @(negedge clk);
    n     = nv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for done; counts cycles where busy dropped before done rose.
  task automatic wait_done(output int cycles, output int busy_gaps, output bit timeout);
    cycles    = 0;
    busy_gaps = 0;
    timeout   = 1'b1;
    for (int c = 0; c < 20000; c++) begin
      if (done) begin
        timeout = 1'b0;
        break;
      end
      if (!busy) busy_gaps++;
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic run_and_check(input logic [DW-1:0] nv, input logic [CNT_W-1:0] exp_sol);
    int cyc, gaps, ov0;
    bit to;
    ov0 = overlap_cnt;
    start_search(nv);
    wait_done(cyc, gaps, to);
    asserts++;
    if (to) begin
      failures++;
      $display("FAIL timeout n=%0d: done not seen within cycle budget", nv);
    end
    asserts++;
    if (solutions !== exp_sol) begin
      failures++;
      $display("FAIL solutions n=%0d: got %0d expected %0d", nv, solutions, exp_sol);
    end
    asserts++;
    if (gaps !== 0) begin
      failures++;
      $display("FAIL busy n=%0d: busy low in %0d search cycles, expected 0", nv, gaps);
    end
    asserts++;
    if (overlap_cnt !== ov0) begin
      failures++;
      $display("FAIL load_read_overlap n=%0d: %0d overlapping cycles, expected 0", nv, overlap_cnt - ov0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    n     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    asserts++;
    if ({busy, done, load_3, read_3} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags: busy/done/load/read=%b expected 0000", {busy, done, load_3, read_3});
    end
    asserts++;
    if (solutions !== '0) begin
      failures++;
      $display("FAIL reset_solutions: got %0d expected 0", solutions);
    end
    asserts++;
    if ({row, col, address_3, data_in_3} !== 12'h000) begin
      failures++;
      $display("FAIL reset_indices: row=%0d col=%0d addr=%0d data=%0d expected all 0", row, col, address_3, data_in_3);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_n4();
    cap_en   = 1'b1;
    cap_done = 1'b0;
    run_and_check(3'd4, 8'd2);
    cap_en = 1'b0;
    asserts++;
    if (!cap_done || cap_addr !== 3'd3 || cap_data !== 3'd2) begin
      failures++;
      $display("FAIL first_solution_write: seen=%0b addr=%0d data=%0d expected addr 3 data 2", cap_done, cap_addr, cap_data);
    end
    asserts++;
    if ({cap_r0, cap_r1, cap_r2} !== {3'd1, 3'd3, 3'd0}) begin
      failures++;
      $display("FAIL first_solution_rows: rows=%0d,%0d,%0d expected 1,3,0", cap_r0, cap_r1, cap_r2);
    end
    repeat (4) @(negedge clk);
    asserts++;
    if (done !== 1'b1 || solutions !== 8'd2) begin
      failures++;
      $display("FAIL done_sticky: done=%0b solutions=%0d expected 1 and 2", done, solutions);
    end
  endtask

  task automatic test_small();
    start_search(3'd0);
    asserts++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL n0_accept: busy=%0b done=%0b expected 1 0", busy, done);
    end
    @(negedge clk);
    asserts++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL n0_early: done=%0b two cycles after start, expected 0", done);
    end
    @(negedge clk);
    asserts++;
    if (done !== 1'b1 || busy !== 1'b0 || solutions !== '0) begin
      failures++;
      $display("FAIL n0_finish: done=%0b busy=%0b sol=%0d expected 1 0 0", done, busy, solutions);
    end
    run_and_check(3'd1, 8'd1);
    run_and_check(3'd2, 8'd0);
    run_and_check(3'd3, 8'd0);
  endtask

  task automatic test_large();
    run_and_check(3'd5, 8'd10);
    run_and_check(3'd6, 8'd4);
    run_and_check(3'd7, 8'd40);
  endtask

  task automatic test_ignore_start();
    int cyc, gaps;
    bit to;
    start_search(3'd6);
    repeat (40) @(negedge clk);
    n     = 3'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, gaps, to);
    asserts++;
    if (to || solutions !== 8'd4) begin
      failures++;
      $display("FAIL ignore_start: timeout=%0b solutions=%0d expected 4", to, solutions);
    end
  endtask

  task automatic test_reset_mid();
    start_search(3'd7);
    repeat (100) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    asserts++;
    if (busy !== 1'b0 || done !== 1'b0 || solutions !== '0 || dut.state !== IDLE) begin
      failures++;
      $display("FAIL reset_mid: busy=%0b done=%0b sol=%0d state=%0d expected 0 0 0 IDLE", busy, done, solutions, dut.state);
    end
    run_and_check(3'd4, 8'd2);
  endtask

  initial begin
    test_reset();
    test_n4();
    test_small();
    test_large();
    test_ignore_start();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
